// File: rtl/alu_issue.sv
// RV32I OP / OP-IMM issue stage.
// Decodes an instruction on acceptance and hands the decoded operand
// payload to the arithmetic unit through an output register backed by a
// single skid register. in_ready is a flop, so it never depends
// combinationally on out_ready.
module alu_issue #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs1_val,
    input  logic [DATA_WIDTH-1:0] rs2_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] lhs,
    output logic [DATA_WIDTH-1:0] rhs,
    output logic [2:0]            operation,
    output logic [6:0]            metadata,
    output logic [4:0]            rd,
    output logic                  illegal
);

    // Payload layout: {illegal, rd, metadata, operation, rhs, lhs}
    localparam int PW = 2 * DATA_WIDTH + 16;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] F7_ZERO    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // The rs1 field selects rs1_val upstream; it is not needed here.
    logic unused_rs1_field;
    assign unused_rs1_field = ^instr[19:15];

    logic [DATA_WIDTH-1:0] dec_lhs;
    logic [DATA_WIDTH-1:0] dec_rhs;
    logic [2:0]            dec_op;
    logic [6:0]            dec_meta;
    logic                  dec_legal;
    logic [PW-1:0]         dec_payload;

    // Decode the offered instruction into operands and legality.
    always_comb begin
        dec_lhs   = '0;
        dec_rhs   = '0;
        dec_op    = '0;
        dec_meta  = '0;
        dec_legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_lhs   = rs1_val;
                dec_rhs   = rs2_val;
                dec_op    = funct3;
                dec_meta  = funct7;
                dec_legal = (funct7 == F7_ZERO) ||
                            ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
            end
            OPC_OP_IMM: begin
                dec_lhs = rs1_val;
                dec_op  = funct3;
                if ((funct3 == 3'd1) || (funct3 == 3'd5)) begin
                    // Shifts: 5-bit shamt, funct7 distinguishes logical/arithmetic.
                    dec_rhs   = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
                    dec_meta  = funct7;
                    dec_legal = (funct7 == F7_ZERO) ||
                                ((funct7 == F7_ALT) && (funct3 == 3'd5));
                end else begin
                    dec_rhs   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
                    dec_meta  = F7_ZERO;
                    dec_legal = 1'b1;
                end
            end
            default: dec_legal = 1'b0;
        endcase

        // Illegal payloads carry a neutral operation so downstream never
        // sees an unsupported {operation, metadata} pair.
        if (dec_legal) begin
            dec_payload = {1'b0, instr[11:7], dec_meta, dec_op, dec_rhs, dec_lhs};
        end else begin
            dec_payload = {1'b1, instr[11:7], 7'd0, 3'd0, {DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}};
        end
    end

    logic [PW-1:0] out_q,  out_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          out_valid_q,  out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          in_ready_q,   in_ready_d;

    logic accept;
    logic consume;

    assign accept  = in_valid && in_ready_q;
    assign consume = out_valid_q && out_ready;

    // Next-state for the output/skid pair.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            // in_ready is low while the skid is occupied, so no accept here.
            if (out_ready) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || out_ready) begin
                out_d       = dec_payload;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec_payload;
                skid_valid_d = 1'b1;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers; reset empties both stages and holds in_ready low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign {illegal, rd, metadata, operation, rhs, lhs} = out_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, backpressure through the
// skid register, sustained throughput and asynchronous reset.
`timescale 1ns/1ps
module tb_alu_issue;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instr = '0;
    logic [DW-1:0] rs1_val = '0;
    logic [DW-1:0] rs2_val = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] lhs;
    logic [DW-1:0] rhs;
    logic [2:0]    operation;
    logic [6:0]    metadata;
    logic [4:0]    rd;
    logic          illegal;

    alu_issue #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lhs       (lhs),
        .rhs       (rhs),
        .operation (operation),
        .metadata  (metadata),
        .rd        (rd),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic last_acc = 1'b0;
    logic [4:0] fire_rd[$];
    int         fire_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One clock: log handshakes from the stable pre-edge values, then
    // advance to just after the rising edge.
    task automatic tick();
        if (out_valid && out_ready) begin
            fire_rd.push_back(rd);
            fire_cyc.push_back(cyc);
        end
        last_acc = in_valid && in_ready;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] e_lhs, input logic [31:0] e_rhs,
                              input logic [2:0] e_op, input logic [6:0] e_meta,
                              input logic [4:0] e_rd, input logic e_ill);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".lhs"},   64'(lhs),       64'(e_lhs));
        check({tag, ".rhs"},   64'(rhs),       64'(e_rhs));
        check({tag, ".op"},    64'(operation), 64'(e_op));
        check({tag, ".meta"},  64'(metadata),  64'(e_meta));
        check({tag, ".rd"},    64'(rd),        64'(e_rd));
        check({tag, ".ill"},   64'(illegal),   64'(e_ill));
    endtask

    // Offer one instruction with out_ready high; it appears one cycle later.
    task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        instr    = i;
        rs1_val  = a;
        rs2_val  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] add_rd(input int r);
        logic [31:0] base;
        base = 32'h0020_8033;
        return base | (32'(r) << 7);
    endfunction

    initial begin
        // Reset asserted from time 0.
        #3;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd0);
        check("rst.illegal",   64'(illegal),   64'd0);
        check("rst.lhs",       64'(lhs),       64'd0);
        #19;                       // t=22, between edges
        rst = 1'b1;
        #1;
        check("rel.in_ready_before_edge", 64'(in_ready), 64'd0);
        tick();
        check("rel.in_ready_after_edge", 64'(in_ready), 64'd1);
        check("rel.out_valid", 64'(out_valid), 64'd0);

        out_ready = 1'b1;

        apply(32'h0020_81B3, 32'd5, 32'd7);
        expect_out("add", 32'd5, 32'd7, 3'd0, 7'h00, 5'd3, 1'b0);
        tick();
        check("add.drained", 64'(out_valid), 64'd0);

        apply(32'hFFF0_0093, 32'd0, 32'd99);
        expect_out("addi", 32'd0, 32'hFFFF_FFFF, 3'd0, 7'h00, 5'd1, 1'b0);
        tick();

        apply(32'h4043_5293, 32'h8000_0000, 32'd1);
        expect_out("srai", 32'h8000_0000, 32'd4, 3'd5, 7'h20, 5'd5, 1'b0);
        tick();

        apply(32'h4020_8233, 32'd10, 32'd3);
        expect_out("sub", 32'd10, 32'd3, 3'd0, 7'h20, 5'd4, 1'b0);
        tick();

        apply(32'h4020_C1B3, 32'd11, 32'd12);
        expect_out("ill_xor", 32'd0, 32'd0, 3'd0, 7'h00, 5'd3, 1'b1);
        tick();

        apply(32'h0000_007F, 32'd11, 32'd12);
        expect_out("ill_opc", 32'd0, 32'd0, 3'd0, 7'h00, 5'd0, 1'b1);
        tick();

        apply(32'h4030_9093, 32'd11, 32'd12);
        expect_out("ill_slli", 32'd0, 32'd0, 3'd0, 7'h00, 5'd1, 1'b1);
        tick();
        check("idle.out_valid", 64'(out_valid), 64'd0);

        // Backpressure: output then skid fill, third offer is held off.
        out_ready = 1'b0;
        rs1_val   = 32'd1;
        rs2_val   = 32'd2;
        instr     = add_rd(1);
        in_valid  = 1'b1;
        check("bp.ready0", 64'(in_ready), 64'd1);
        tick();
        check("bp.rd_a", 64'(rd), 64'd1);
        check("bp.ready1", 64'(in_ready), 64'd1);
        instr = add_rd(2);
        tick();
        check("bp.ready2", 64'(in_ready), 64'd0);
        check("bp.rd_b", 64'(rd), 64'd1);
        instr = add_rd(3);
        tick();
        check("bp.ready3", 64'(in_ready), 64'd0);
        check("bp.hold_valid", 64'(out_valid), 64'd1);
        check("bp.hold_rd", 64'(rd), 64'd1);
        fire_rd.delete();
        fire_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (last_acc) in_valid = 1'b0;
        end
        check("bp.count", 64'(fire_rd.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp.order%0d", k),
                  64'((fire_rd.size() > k) ? fire_rd[k] : 5'h1F), 64'(k + 1));
        end
        for (int k = 1; k < 3; k++) begin
            check($sformatf("bp.gap%0d", k),
                  64'((fire_cyc.size() > k) ? (fire_cyc[k] - fire_cyc[k-1]) : 99), 64'd1);
        end

        // Sustained throughput with out_ready held high.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr = add_rd(k + 4);
            tick();
            check($sformatf("tp.rd%0d", k), 64'(rd), 64'(k + 4));
            check($sformatf("tp.valid%0d", k), 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("tp.drained", 64'(out_valid), 64'd0);

        // Reset with both stages full.
        out_ready = 1'b0;
        instr     = add_rd(7);
        in_valid  = 1'b1;
        tick();
        instr = add_rd(8);
        tick();
        in_valid = 1'b0;
        check("mr.full_valid", 64'(out_valid), 64'd1);
        check("mr.full_ready", 64'(in_ready), 64'd0);
        #3;
        rst = 1'b0;
        #1;
        check("mr.out_valid", 64'(out_valid), 64'd0);
        check("mr.in_ready",  64'(in_ready),  64'd0);
        check("mr.rd",        64'(rd),        64'd0);
        check("mr.lhs",       64'(lhs),       64'd0);
        #2;
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        check("mr.rel_ready", 64'(in_ready), 64'd1);
        check("mr.rel_valid0", 64'(out_valid), 64'd0);
        tick();
        check("mr.rel_valid1", 64'(out_valid), 64'd0);
        apply(32'h0020_81B3, 32'd20, 32'd22);
        expect_out("mr.new", 32'd20, 32'd22, 3'd0, 7'h00, 5'd3, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk, input, 1, sole clock; all state rises on posedge clk.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, upstream offers an instruction.
REQ-005 SHALL have port in_ready, output, 1, block accepts the offer this cycle.
REQ-006 SHALL have port instr, input, 32, RV32I instruction word.
REQ-007 SHALL have port rs1_val, input, DATA_WIDTH, register-file value of rs1.
REQ-008 SHALL have port rs2_val, input, DATA_WIDTH, register-file value of rs2.
REQ-009 SHALL have port out_valid, output, 1, issue payload valid.
REQ-010 SHALL have port out_ready, input, 1, arithmetic stage consumes the payload.
REQ-011 SHALL have ports lhs and rhs, output, DATA_WIDTH each, operands to the arithmetic unit.
REQ-012 SHALL have port operation, output, 3, funct3 to the arithmetic unit.
REQ-013 SHALL have port metadata, output, 7, funct7 to the arithmetic unit.
REQ-014 SHALL have port rd, output, 5, destination register (instr[11:7]).
REQ-015 SHALL have port illegal, output, 1, payload is not a legal OP/OP-IMM instruction.

Function
REQ-016 SHALL decode at acceptance and store only the decoded payload {lhs, rhs, operation, metadata, rd, illegal}.
REQ-017 OP (opcode 0x33) SHALL give lhs=rs1_val, rhs=rs2_val, operation=funct3, metadata=funct7.
REQ-018 OP legality SHALL be: funct7=0x00 for any funct3; funct7=0x20 only with funct3 0 or 5.
REQ-019 OP-IMM (opcode 0x13), funct3 in {0,2,3,4,6,7}, SHALL give lhs=rs1_val, rhs=instr[31:20] sign-extended to DATA_WIDTH, metadata=0x00, always legal.
REQ-020 OP-IMM funct3 1/5 SHALL give rhs=instr[24:20] zero-extended, metadata=instr[31:25]; legal only for metadata 0x00, or 0x20 with funct3 5.
REQ-021 Any other opcode or illegal pattern SHALL set illegal=1 and force lhs=0, rhs=0, operation=0, metadata=0x00, so the downstream stage never sees an unsupported {operation, metadata}.
REQ-022 Handshake: transfer on in_valid&&in_ready (input) and out_valid&&out_ready (output); payload and out_valid SHALL be held stable while out_valid&&!out_ready.
REQ-023 Buffering SHALL be an output register plus one skid register; in_ready = !skid_valid, registered (no combinational path from out_ready).
REQ-024 Accept with output empty, or output being consumed that cycle: load output register; out_valid=1 next cycle (latency 1 cycle).
REQ-025 Accept with output full and not consumed: load skid register; in_ready=0 next cycle.
REQ-026 Skid full and out_ready=1: skid moves to output register, skid cleared, in_ready=1 next cycle.
REQ-027 Output consumed, no accept, skid empty: out_valid=0 next cycle.
REQ-028 Order SHALL be preserved; sustained throughput SHALL be 1 instruction/cycle with out_ready held high.
REQ-029 in_valid with in_ready=0 SHALL not alter state; instruction SHALL be neither dropped nor duplicated.

Reset
REQ-030 rst=0 SHALL immediately clear out_valid, skid_valid, and all payload registers to 0 (illegal=0), independent of clk.
REQ-031 in_ready SHALL read 0 while rst=0 and 1 from the first posedge after rst deasserts.
REQ-032 Reset mid-transfer SHALL discard all buffered instructions; none appear at the output after release.

Verification
REQ-033 ADD x3,x1,x2: instr=0x002081B3, rs1_val=5, rs2_val=7, out_ready=1 -> next cycle out_valid=1, lhs=5, rhs=7, operation=0, metadata=0x00, rd=3, illegal=0.
REQ-034 ADDI x1,x0,-1: instr=0xFFF00093, rs1_val=0 -> rhs=0xFFFFFFFF, operation=0, metadata=0x00, rd=1.
REQ-035 SRAI x5,x6,4: instr=0x40435293, rs1_val=0x80000000 -> lhs=0x80000000, rhs=4, operation=5, metadata=0x20, rd=5.
REQ-036 Illegal: instr=0x4020C1B3 (funct7 0x20 with XOR), then 0x0000007F -> two payloads with illegal=1, lhs=rhs=0, operation=0, metadata=0x00.
REQ-037 Backpressure: out_ready=0, offer 3 back-to-back ADDs (rd=1,2,3) -> first two accepted, in_ready=0 after second; then out_ready=1 -> rd 1,2,3 emerge in order on consecutive cycles, no loss or duplicate.
REQ-038 Reset mid-operation: output and skid full, pull rst low between edges -> out_valid=0 and in_ready=0 immediately; after release, out_valid stays 0 until a new accept.
